// File: rtl/sprite_gen_arbiter_if.sv
// sprite_gen_arbiter_if: bundles the engine read handshake, the host write
// path and the generator-table RAM ports of sprite_gen_arbiter.
//   req/req_addr      engines -> arbiter, per-requester request and address
//   gnt/rvalid/rdata  arbiter -> engines, one-hot grant, one-hot data valid
//   host_we/wa/wd     host write strobe, address, data
//   host_full         FIFO full; overflow is sticky on a dropped write
//   vblank            drain window for deferred host writes
//   mem_ra/mem_dout   table read port (registered read, 1-cycle latency)
//   mem_we/wa/din     table write port
// slave = arbiter side, master = environment side.
interface sprite_gen_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 8,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;
  logic               host_we;
  logic [AW-1:0]      host_wa;
  logic [DW-1:0]      host_wd;
  logic               host_full;
  logic               overflow;
  logic               vblank;
  logic [AW-1:0]      mem_ra;
  logic [DW-1:0]      mem_dout;
  logic               mem_we;
  logic [AW-1:0]      mem_wa;
  logic [DW-1:0]      mem_din;

  modport slave (
    input  req, req_addr, host_we, host_wa, host_wd, vblank, mem_dout,
    output gnt, rvalid, rdata, host_full, overflow, mem_ra, mem_we, mem_wa, mem_din
  );

  modport master (
    output req, req_addr, host_we, host_wa, host_wd, vblank, mem_dout,
    input  gnt, rvalid, rdata, host_full, overflow, mem_ra, mem_we, mem_wa, mem_din
  );
endinterface

// File: rtl/sprite_gen_arbiter.sv
// sprite_gen_arbiter: round-robin share of the sprite generator table read
// port among NREQ engines, plus a host write FIFO drained only in vblank so
// the visible frame never sees half-updated sprite data.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high
//   bus    sprite_gen_arbiter_if.slave (engine, host and RAM signals)
module sprite_gen_arbiter #(
  parameter int NREQ   = 4,
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int WDEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  sprite_gen_arbiter_if.slave   bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int FW = (WDEPTH > 1) ? $clog2(WDEPTH) : 1;
  localparam int EW = AW + DW;

  // ---------------- read arbitration ----------------
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   win;
  logic            found;
  logic [PW:0]     j;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rvalid_q;
  logic [AW-1:0]   mem_ra_q, mem_ra_d;

  // Scan from the pointer, wrapping at NREQ (need not be a power of two).
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = {1'b0, ptr_q} + (PW+1)'(k);
      if (j >= (PW+1)'(NREQ)) j = j - (PW+1)'(NREQ);
      if (!found && bus.req[j[PW-1:0]]) begin
        found = 1'b1;
        win   = j[PW-1:0];
      end
    end
  end

  generate
    for (genvar g = 0; g < NREQ; g++) begin : g_gnt
      assign gnt_d[g] = found && (win == PW'(g));
    end
  endgenerate

  always_comb begin
    ptr_d    = ptr_q;
    mem_ra_d = mem_ra_q;
    if (found) begin
      ptr_d    = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
      mem_ra_d = bus.req_addr[win*AW +: AW];
    end
  end

  // gnt_q doubles as the tag stage: one edge later it lines up with the
  // RAM's registered output. Reset empties both stages, so grants in flight
  // at reset never produce rvalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q    <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      mem_ra_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      rvalid_q <= gnt_q;
      mem_ra_q <= mem_ra_d;
    end
  end

  // ---------------- host write FIFO ----------------
  logic [EW-1:0] fifo_q [WDEPTH];
  logic [FW-1:0] wp_q, rp_q;
  logic [FW:0]   cnt_q, cnt_d;
  logic          push, pop;
  logic          mem_we_q;
  logic [AW-1:0] mem_wa_q;
  logic [DW-1:0] mem_din_q;
  logic          host_full_q, overflow_q;

  assign pop   = bus.vblank && (cnt_q != '0);
  // A full FIFO still accepts a write on an edge that also drains one.
  assign push  = bus.host_we && ((cnt_q != (FW+1)'(WDEPTH)) || pop);

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wp_q] <= {bus.host_wa, bus.host_wd};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q        <= '0;
      rp_q        <= '0;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_wa_q    <= '0;
      mem_din_q   <= '0;
      host_full_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      host_full_q <= (cnt_d == (FW+1)'(WDEPTH));
      mem_we_q    <= pop;
      if (push) wp_q <= wp_q + 1'b1;
      if (pop) begin
        rp_q                  <= rp_q + 1'b1;
        {mem_wa_q, mem_din_q} <= fifo_q[rp_q];
      end
      if (bus.host_we && !push) overflow_q <= 1'b1;
    end
  end

  // ---------------- outputs ----------------
  assign bus.gnt       = gnt_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = bus.mem_dout;
  assign bus.mem_ra    = mem_ra_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wa    = mem_wa_q;
  assign bus.mem_din   = mem_din_q;
  assign bus.host_full = host_full_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_sprite_gen_arbiter.sv
module tb_sprite_gen_arbiter;
  localparam int NREQ = 4, AW = 8, DW = 8, WDEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0, n_err = 0;

  sprite_gen_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus();

  sprite_gen_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .WDEPTH(WDEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #10 clk = ~clk;

  // Generator table: registered read, old data on read/write collision.
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    bus.mem_dout <= ram[bus.mem_ra];
    if (bus.mem_we) ram[bus.mem_wa] <= bus.mem_din;
  end

  typedef struct packed { logic [NREQ-1:0] id; logic [DW-1:0] d; } rd_t;
  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  rd_t rd_q[$];
  wr_t wr_q[$];
  rd_t re;
  wr_t we;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Scoreboard: every rvalid / mem_we must match the next expected entry.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rvalid != '0) begin
        if (rd_q.size() == 0) chk("rv_unexp", 32'(bus.rvalid), 32'h0);
        else begin
          re = rd_q.pop_front();
          chk("rv_id", 32'(bus.rvalid), 32'(re.id));
          chk("rdata", 32'(bus.rdata), 32'(re.d));
        end
      end
      if (bus.mem_we) begin
        if (wr_q.size() == 0) chk("we_unexp", 32'(bus.mem_we), 32'h0);
        else begin
          we = wr_q.pop_front();
          chk("mem_wa", 32'(bus.mem_wa), 32'(we.a));
          chk("mem_din", 32'(bus.mem_din), 32'(we.d));
        end
      end
    end
  end

  task automatic host_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit expect_drain);
    bus.host_we = 1'b1;
    bus.host_wa = a;
    bus.host_wd = d;
    if (expect_drain) wr_q.push_back({a, d});
    cyc();
    bus.host_we = 1'b0;
  endtask

  logic [NREQ-1:0] g2 [5];
  logic [DW-1:0]   d2 [5];
  logic [NREQ-1:0] g3 [3];

  initial begin
    bus.req = '0; bus.req_addr = '0; bus.host_we = 1'b0;
    bus.host_wa = '0; bus.host_wd = '0; bus.vblank = 1'b0;
    g2 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    d2 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    g3 = '{4'b0001, 4'b0010, 4'b0001};

    // reset values
    repeat (2) cyc();
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_rvalid", 32'(bus.rvalid), 0);
    chk("rst_mem_ra", 32'(bus.mem_ra), 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_mem_wa", 32'(bus.mem_wa), 0);
    chk("rst_mem_din", 32'(bus.mem_din), 0);
    chk("rst_full", 32'(bus.host_full), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    reset = 1'b0;

    // preload the table through the host path during vblank
    bus.vblank = 1'b1;
    host_wr(8'h10, 8'hA5, 1);
    host_wr(8'h20, 8'h11, 1);
    host_wr(8'h21, 8'h22, 1);
    host_wr(8'h22, 8'h33, 1);
    host_wr(8'h23, 8'h44, 1);
    repeat (4) cyc();
    bus.vblank = 1'b0;
    cyc();

    // single read: grant next cycle, data one cycle after that
    bus.req_addr[0*AW +: AW] = 8'h10;
    bus.req = 4'b0001;
    rd_q.push_back({4'b0001, 8'hA5});
    cyc();
    chk("t1_gnt", 32'(bus.gnt), 32'h1);
    chk("t1_ra", 32'(bus.mem_ra), 32'h10);
    bus.req = '0;
    cyc();
    chk("t1_gnt_idle", 32'(bus.gnt), 0);
    chk("t1_rv", 32'(bus.rvalid), 32'h1);
    cyc();

    // all four requesting, from pointer 0
    reset = 1'b1; cyc(); reset = 1'b0;
    for (int i = 0; i < NREQ; i++) bus.req_addr[i*AW +: AW] = AW'(8'h20 + i);
    for (int i = 0; i < 5; i++) rd_q.push_back({g2[i], d2[i]});
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t2_gnt", 32'(bus.gnt), 32'(g2[i]));
      if (i > 0) chk("t2_rv_align", 32'(bus.rvalid), 32'(g2[i-1]));
    end
    bus.req = '0;
    cyc();
    chk("t2_rv_last", 32'(bus.rvalid), 32'(g2[4]));
    cyc();

    // move pointer to 2, then requesters 0 and 1 alternate
    bus.req = 4'b0010;
    rd_q.push_back({4'b0010, 8'h22});
    cyc();
    chk("t3_pre_gnt", 32'(bus.gnt), 32'h2);
    bus.req = '0;
    cyc();
    for (int i = 0; i < 3; i++) rd_q.push_back({g3[i], (g3[i] == 4'b0001) ? 8'h11 : 8'h22});
    bus.req = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t3_gnt", 32'(bus.gnt), 32'(g3[i]));
    end
    bus.req = '0;
    repeat (2) cyc();

    // fill FIFO outside vblank; fifth write is dropped
    for (int i = 0; i < 5; i++) begin
      host_wr(AW'(8'h30 + i), DW'(8'hC0 + i), i < 4);
      if (i == 2) chk("t4_not_full", 32'(bus.host_full), 0);
      if (i == 3) begin
        chk("t4_full", 32'(bus.host_full), 1);
        chk("t4_no_ovf", 32'(bus.overflow), 0);
      end
      if (i == 4) begin
        chk("t4_ovf", 32'(bus.overflow), 1);
        chk("t4_full2", 32'(bus.host_full), 1);
      end
      chk("t4_no_we", 32'(bus.mem_we), 0);
    end
    cyc();
    chk("t4_no_we_idle", 32'(bus.mem_we), 0);

    // drain in vblank: four consecutive writes, then empty
    bus.vblank = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t5_we", 32'(bus.mem_we), 1);
    end
    cyc();
    chk("t5_empty", 32'(bus.mem_we), 0);
    chk("t5_not_full", 32'(bus.host_full), 0);
    chk("t5_ovf_sticky", 32'(bus.overflow), 1);
    bus.vblank = 1'b0;

    // reset with a read in flight and two queued writes
    host_wr(8'h40, 8'h01, 0);
    host_wr(8'h41, 8'h02, 0);
    bus.req_addr[0*AW +: AW] = 8'h10;
    bus.req = 4'b0001;
    cyc();
    chk("t6_gnt", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    #2 reset = 1'b1;
    #1;
    chk("t6_gnt_rst", 32'(bus.gnt), 0);
    chk("t6_rv_rst", 32'(bus.rvalid), 0);
    chk("t6_ra_rst", 32'(bus.mem_ra), 0);
    chk("t6_ovf_rst", 32'(bus.overflow), 0);
    chk("t6_full_rst", 32'(bus.host_full), 0);
    chk("t6_we_rst", 32'(bus.mem_we), 0);
    cyc();
    reset = 1'b0;
    bus.vblank = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t6_no_drain", 32'(bus.mem_we), 0);
      chk("t6_no_rv", 32'(bus.rvalid), 0);
    end
    bus.vblank = 1'b0;
    cyc();

    chk("rd_q_left", 32'(rd_q.size()), 0);
    chk("wr_q_left", 32'(wr_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
